// File: rtl/ila_readout_pkg.sv
// ============================================================================
// Module      : ila_readout_pkg
// Description : Shared types and helpers for the ILA readout sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ila_readout_pkg;

    typedef enum logic [1:0] {
        ILA_RD_IDLE  = 2'd0,
        ILA_RD_FETCH = 2'd1,
        ILA_RD_SEND  = 2'd2,
        ILA_RD_FIN   = 2'd3
    } ila_rd_state_t;

    localparam int c_ila_data_w_dflt   = 32;
    localparam int c_ila_buffer_w_dflt = 10;
    localparam int c_ila_parts_dflt    = 2;

    // A slice select always needs at least one bit, even for single-slice samples.
    function automatic int ila_sel_w(input int parts);
        return (parts > 1) ? $clog2(parts) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ila_readout_addr_gen.sv
// ============================================================================
// Module      : ila_readout_addr_gen
// Description : Nested slice/sample counter walking the ILA buffer read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ila_readout_addr_gen #(
    parameter int BUFFER_W = 10,
    parameter int PARTS    = 2,
    parameter int SEL_W    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                adv,
    input  logic [BUFFER_W-1:0] n,
    output logic [BUFFER_W-1:0] index,
    output logic [SEL_W-1:0]    sel,
    output logic                last
);

    logic [BUFFER_W-1:0] r_index;
    logic [SEL_W-1:0]    w_sel;
    logic                w_sel_last;
    logic                w_index_last;

    // n >= 1 whenever this flag is consumed, so n-1 never wraps.
    assign w_index_last = (r_index == (n - BUFFER_W'(1)));

    generate
        if (PARTS > 1) begin : g_multi_part
            localparam logic [SEL_W-1:0] c_sel_max = SEL_W'(PARTS - 1);
            logic [SEL_W-1:0] r_sel;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sel <= '0;
                end else if (clr) begin
                    r_sel <= '0;
                end else if (adv) begin
                    r_sel <= w_sel_last ? '0 : r_sel + SEL_W'(1);
                end
            end

            assign w_sel      = r_sel;
            assign w_sel_last = (r_sel == c_sel_max);
        end else begin : g_single_part
            assign w_sel      = '0;
            assign w_sel_last = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (clr) begin
            r_index <= '0;
        end else if (adv && w_sel_last) begin
            r_index <= r_index + BUFFER_W'(1);
        end
    end

    assign index = r_index;
    assign sel   = w_sel;
    assign last  = w_index_last && w_sel_last;

endmodule

`default_nettype wire

// File: rtl/ila_readout_ctrl.sv
// ============================================================================
// Module      : ila_readout_ctrl
// Description : Streams the ILA capture buffer out over valid/ready, one
//               DATA_W slice per word. Optional macro ILA_READOUT_AUTOCLR_EN
//               pulses rst_soft on normal completion to re-arm capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ila_readout_ctrl
    import ila_readout_pkg::*;
#(
    parameter int DATA_W   = c_ila_data_w_dflt,
    parameter int BUFFER_W = c_ila_buffer_w_dflt,
    parameter int PARTS    = c_ila_parts_dflt,
    parameter int SEL_W    = ila_sel_w(PARTS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    input  logic [BUFFER_W-1:0] samples,
    output logic [BUFFER_W-1:0] index,
    output logic [SEL_W-1:0]    value_select,
    input  logic [DATA_W-1:0]   value,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    output logic                rst_soft
);

    ila_rd_state_t       r_state;
    logic [BUFFER_W-1:0] r_n;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_last;

    logic                w_start_ok;
    logic                w_abort_run;
    logic                w_clr;
    logic                w_adv;
    logic                w_last;

    assign w_start_ok  = (r_state == ILA_RD_IDLE) && start && !abort;
    assign w_abort_run = abort && (r_state != ILA_RD_IDLE);
    assign w_clr       = w_start_ok || w_abort_run;
    assign w_adv       = (r_state == ILA_RD_SEND) && m_ready && !w_last;

    ila_readout_addr_gen #(
        .BUFFER_W (BUFFER_W),
        .PARTS    (PARTS),
        .SEL_W    (SEL_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .adv   (w_adv),
        .n     (r_n),
        .index (index),
        .sel   (value_select),
        .last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ILA_RD_IDLE;
            r_n     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_run) begin
                r_state <= ILA_RD_IDLE;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                case (r_state)
                    ILA_RD_IDLE: begin
                        if (w_start_ok) begin
                            r_busy <= 1'b1;
                            if (samples == '0) begin
                                r_state <= ILA_RD_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_n     <= samples;
                                r_state <= ILA_RD_FETCH;
                            end
                        end
                    end
                    // The core's read register catches up with index/sel here.
                    ILA_RD_FETCH: begin
                        r_state <= ILA_RD_SEND;
                        r_valid <= 1'b1;
                        r_last  <= w_last;
                    end
                    ILA_RD_SEND: begin
                        if (m_ready) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (w_last) begin
                                r_state <= ILA_RD_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ILA_RD_FETCH;
                            end
                        end
                    end
                    ILA_RD_FIN: begin
                        r_state <= ILA_RD_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ILA_RD_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ILA_READOUT_AUTOCLR_EN
    logic r_rst_soft;

    // Only a completed readout re-arms the core; the empty path never sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_soft <= 1'b0;
        end else begin
            r_rst_soft <= (r_state == ILA_RD_SEND) && m_ready && w_last && !abort;
        end
    end

    assign rst_soft = r_rst_soft;
`else
    assign rst_soft = 1'b0;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign m_data  = r_valid ? value : '0;

endmodule

`default_nettype wire

// File: tb/tb_ila_readout_ctrl.sv
// ============================================================================
// Module      : tb_ila_readout_ctrl
// Description : Self-checking bench for ila_readout_ctrl with a registered
//               core read-port model and a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ila_readout_ctrl;

    localparam int DATA_W   = 32;
    localparam int BUFFER_W = 10;
    localparam int PARTS    = 2;
    localparam int SEL_W    = 1;

`ifdef ILA_READOUT_AUTOCLR_EN
    localparam bit c_autoclr = 1'b1;
`else
    localparam bit c_autoclr = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [BUFFER_W-1:0] samples;
    logic [BUFFER_W-1:0] index;
    logic [SEL_W-1:0]    value_select;
    logic [DATA_W-1:0]   value;
    logic                m_valid;
    logic                m_ready;
    logic [DATA_W-1:0]   m_data;
    logic                m_last;
    logic                rst_soft;

    int                  n_total;
    int                  n_pass;
    int                  words_seen;
    logic [DATA_W:0]     exp_q[$];

    ila_readout_ctrl #(
        .DATA_W   (DATA_W),
        .BUFFER_W (BUFFER_W),
        .PARTS    (PARTS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .samples      (samples),
        .index        (index),
        .value_select (value_select),
        .value        (value),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .rst_soft     (rst_soft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core read port: registered, returns {index, sel}.
    always @(posedge clk) value <= DATA_W'({index, value_select});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W:0]   mon_e;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid_hold", 64'(m_valid), 64'd1);
                chk("stall_data_hold", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data), 64'hDEAD);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_data", 64'(m_data), 64'(mon_e[DATA_W-1:0]));
                    chk("word_last", 64'(m_last), 64'(mon_e[DATA_W]));
                end
            end
            prev_stall = m_valid && !m_ready && !abort;
            prev_data  = m_data;
        end
    end

    task automatic push_words(input int n, input int upto);
        logic [BUFFER_W-1:0] bi;
        logic [SEL_W-1:0]    bs;
        logic                lst;
        int                  k;
        k = 0;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < PARTS; s++) begin
                bi  = BUFFER_W'(i);
                bs  = SEL_W'(s);
                lst = (i == n - 1) && (s == PARTS - 1);
                if (k < upto) exp_q.push_back({lst, DATA_W'({bi, bs})});
                k++;
            end
        end
    endtask

    // mode 0: m_ready held high; mode 1: m_ready high one cycle in three.
    task automatic run_xfer(input int n, input int mode, input string tag);
        int cyc;
        int seen0;
        seen0 = words_seen;
        push_words(n, n * PARTS);
        samples = BUFFER_W'(n);
        start   = 1'b1;
        m_ready = (mode == 0);
        step();
        start   = 1'b0;
        samples = BUFFER_W'(0);
        cyc     = 1;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        chk({tag, "_no_valid_first"}, 64'(m_valid), 64'd0);
        while (!done && cyc < 300) begin
            chk({tag, "_rst_soft_quiet"}, 64'(rst_soft), 64'd0);
            if (mode == 1) m_ready = ((cyc % 3) == 0);
            step();
            cyc++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        if (mode == 0) chk({tag, "_done_cycle"}, 64'(cyc), 64'(2 * n * PARTS + 1));
        chk({tag, "_rst_soft_fin"}, 64'(rst_soft), 64'(c_autoclr && (n > 0)));
        chk({tag, "_busy_fin"}, 64'(busy), 64'd1);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        chk({tag, "_rst_soft_clear"}, 64'(rst_soft), 64'd0);
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_word_count"}, 64'(words_seen - seen0), 64'(n * PARTS));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_index"}, 64'(index), 64'd0);
        chk({tag, "_sel"}, 64'(value_select), 64'd0);
        chk({tag, "_rst_soft"}, 64'(rst_soft), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int seen_done;
        n_total    = 0;
        n_pass     = 0;
        words_seen = 0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        m_ready    = 1'b0;
        samples    = '0;
        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        run_xfer(3, 0, "basic");
        run_xfer(3, 1, "backpressure");
        run_xfer(0, 0, "empty");

        // Abort during the third SEND; only the first two words are accepted.
        push_words(3, 2);
        samples = BUFFER_W'(3);
        start   = 1'b1;
        m_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        m_ready = 1'b0;
        abort   = 1'b1;
        chk("abort_in_send", 64'(m_valid), 64'd1);
        chk("abort_idx_before", 64'(index), 64'd1);
        step();
        abort = 1'b0;
        chk("abort_valid_drop", 64'(m_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_index", 64'(index), 64'd0);
        chk("abort_sel", 64'(value_select), 64'd0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done++;
            step();
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        chk("abort_queue", 64'(exp_q.size()), 64'd0);
        run_xfer(1, 0, "after_abort");

        // Asynchronous reset while a word is waiting in SEND.
        samples = BUFFER_W'(2);
        m_ready = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("pre_reset_send", 64'(m_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        step();
        rst = 1'b0;
        step();
        run_xfer(2, 0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
